// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Turns EX-stage taken branches into a held redirect to the PC
//               unit, then flushes IF/ID for FLUSH_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int unsigned GAP          = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic             br_taken,
    input  logic [31:0]      pc_next,
    input  logic [31:0]      imm,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_REDIRECT = 2'd1;
    localparam logic [1:0]  c_ST_FLUSH    = 2'd2;

    localparam logic [31:0] c_GAP         = 32'(GAP);
    localparam logic [3:0]  c_FLUSH_LEN   = 4'(FLUSH_CYCLES);

    logic [1:0]       r_state;
    logic [3:0]       r_flush_cnt;
    logic             r_redir_valid;
    logic [31:0]      r_redir_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_ntaken_cnt;

    logic             w_accept;
    logic [31:0]      w_target;

    assign br_ready    = (r_state == c_ST_IDLE);
    assign w_accept    = br_valid & br_ready;
    // Product and sum both truncate to 32 bits; wrap-around is intended.
    assign w_target    = pc_next + (imm * c_GAP);

    assign redir_valid = r_redir_valid;
    assign redir_pc    = r_redir_pc;
    assign flush       = r_flush;
    assign taken_cnt   = r_taken_cnt;
    assign ntaken_cnt  = r_ntaken_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_flush_cnt   <= 4'd0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_flush       <= 1'b0;
            r_taken_cnt   <= '0;
            r_ntaken_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (br_taken) begin
                            r_redir_pc    <= w_target;
                            r_redir_valid <= 1'b1;
                            r_taken_cnt   <= r_taken_cnt + 1'b1;
                            r_state       <= c_ST_REDIRECT;
                        end else begin
                            r_ntaken_cnt  <= r_ntaken_cnt + 1'b1;
                        end
                    end
                end
                c_ST_REDIRECT: begin
                    // redir_pc is left untouched here so it stays stable under back-pressure.
                    if (redir_ready) begin
                        r_redir_valid <= 1'b0;
                        if (c_FLUSH_LEN != 4'd0) begin
                            r_flush_cnt <= c_FLUSH_LEN;
                            r_flush     <= 1'b1;
                            r_state     <= c_ST_FLUSH;
                        end else begin
                            r_state     <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (r_flush_cnt <= 4'd1) begin
                        r_flush_cnt <= 4'd0;
                        r_flush     <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state       <= c_ST_IDLE;
                    r_flush_cnt   <= 4'd0;
                    r_redir_valid <= 1'b0;
                    r_flush       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Directed self-checking bench for branch_redirect_ctrl, with a
//               second instance built with FLUSH_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        br_valid, br_taken, redir_ready;
    logic [31:0] pc_next, imm;
    logic        br_ready, redir_valid, flush;
    logic [31:0] redir_pc;
    logic [15:0] taken_cnt, ntaken_cnt;

    logic        br_valid0, br_taken0, redir_ready0;
    logic [31:0] pc_next0, imm0;
    logic        br_ready0, redir_valid0, flush0;
    logic [31:0] redir_pc0;
    logic [15:0] taken_cnt0, ntaken_cnt0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.GAP(4), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready), .br_taken(br_taken),
        .pc_next(pc_next), .imm(imm),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush(flush), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
    );

    branch_redirect_ctrl #(.GAP(4), .FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid0), .br_ready(br_ready0), .br_taken(br_taken0),
        .pc_next(pc_next0), .imm(imm0),
        .redir_valid(redir_valid0), .redir_ready(redir_ready0), .redir_pc(redir_pc0),
        .flush(flush0), .taken_cnt(taken_cnt0), .ntaken_cnt(ntaken_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance past the next rising edge; outputs are then settled and inputs safe to change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_taken(input logic [31:0] pc, input logic [31:0] im);
        br_valid = 1'b1;
        br_taken = 1'b1;
        pc_next  = pc;
        imm      = im;
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_taken = 1'b0; redir_ready = 1'b0;
        pc_next = 32'd0; imm = 32'd0;
        br_valid0 = 1'b0; br_taken0 = 1'b0; redir_ready0 = 1'b0;
        pc_next0 = 32'd0; imm0 = 32'd0;

        step(); step();
        check("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
        check("rst_flush",       {31'd0, flush},       32'd0);
        check("rst_redir_pc",    redir_pc,             32'd0);
        check("rst_br_ready",    {31'd0, br_ready},    32'd1);
        check("rst_taken_cnt",   {16'd0, taken_cnt},   32'd0);
        check("rst_ntaken_cnt",  {16'd0, ntaken_cnt},  32'd0);
        rst_n = 1'b1;
        step();

        // Basic taken redirect with immediate handshake and 2-cycle flush.
        drive_taken(32'h0000_0100, 32'd3);
        redir_ready = 1'b1;
        step();
        br_valid = 1'b0;
        check("t1_redir_valid", {31'd0, redir_valid}, 32'd1);
        check("t1_redir_pc",    redir_pc,             32'h0000_010C);
        check("t1_taken_cnt",   {16'd0, taken_cnt},   32'd1);
        check("t1_br_ready",    {31'd0, br_ready},    32'd0);
        check("t1_flush_pre",   {31'd0, flush},       32'd0);
        step();
        check("t1_flush_c1",    {31'd0, flush},       32'd1);
        check("t1_valid_off",   {31'd0, redir_valid}, 32'd0);
        step();
        check("t1_flush_c2",    {31'd0, flush},       32'd1);
        check("t1_busy_c2",     {31'd0, br_ready},    32'd0);
        step();
        check("t1_flush_end",   {31'd0, flush},       32'd0);
        check("t1_ready_back",  {31'd0, br_ready},    32'd1);

        // Target wrap-around and negative immediate.
        drive_taken(32'hFFFF_FFF8, 32'd4);
        step();
        br_valid = 1'b0;
        check("t2_wrap_pc", redir_pc, 32'h0000_0008);
        step(); step(); step();
        check("t2_ready_a", {31'd0, br_ready}, 32'd1);
        drive_taken(32'h0000_0020, 32'hFFFF_FFFE);
        step();
        br_valid = 1'b0;
        check("t2_neg_pc",  redir_pc, 32'h0000_0018);
        step(); step(); step();
        check("t2_taken_cnt", {16'd0, taken_cnt}, 32'd3);

        // Back-pressure from the PC unit; busy-time br_valid pulses are ignored.
        redir_ready = 1'b0;
        drive_taken(32'h0000_0040, 32'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            br_valid = (i % 2 == 0);
            br_taken = (i % 4 == 0);
            step();
            check("t3_hold_valid", {31'd0, redir_valid}, 32'd1);
            check("t3_hold_pc",    redir_pc,             32'h0000_0044);
            check("t3_busy",       {31'd0, br_ready},    32'd0);
            check("t3_no_flush",   {31'd0, flush},       32'd0);
        end
        check("t3_taken_cnt",  {16'd0, taken_cnt},  32'd4);
        check("t3_ntaken_cnt", {16'd0, ntaken_cnt}, 32'd0);
        br_valid = 1'b0;
        redir_ready = 1'b1;
        step();
        check("t3_hs_flush", {31'd0, flush}, 32'd1);
        step(); step();
        check("t3_ready_back", {31'd0, br_ready}, 32'd1);

        // Back-to-back not-taken accepts.
        br_valid = 1'b1; br_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_ready",  {31'd0, br_ready},    32'd1);
            check("t4_nvalid", {31'd0, redir_valid}, 32'd0);
            check("t4_nflush", {31'd0, flush},       32'd0);
        end
        br_valid = 1'b0;
        check("t4_ntaken_cnt", {16'd0, ntaken_cnt}, 32'd4);
        check("t4_taken_cnt",  {16'd0, taken_cnt},  32'd4);

        // Reset while in REDIRECT drops the pending redirect.
        redir_ready = 1'b0;
        drive_taken(32'h0000_1000, 32'd2);
        step();
        br_valid = 1'b0;
        check("t5_in_redirect", {31'd0, redir_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        check("t5a_valid",  {31'd0, redir_valid}, 32'd0);
        check("t5a_flush",  {31'd0, flush},       32'd0);
        check("t5a_ready",  {31'd0, br_ready},    32'd1);
        check("t5a_tcnt",   {16'd0, taken_cnt},   32'd0);
        check("t5a_ncnt",   {16'd0, ntaken_cnt},  32'd0);
        rst_n = 1'b1;
        step();
        check("t5a_idle_after", {31'd0, redir_valid}, 32'd0);

        // Reset in the middle of FLUSH.
        redir_ready = 1'b1;
        drive_taken(32'h0000_2000, 32'd1);
        step();
        br_valid = 1'b0;
        step();
        check("t5_in_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        step();
        check("t5b_flush",  {31'd0, flush},       32'd0);
        check("t5b_valid",  {31'd0, redir_valid}, 32'd0);
        check("t5b_ready",  {31'd0, br_ready},    32'd1);
        check("t5b_tcnt",   {16'd0, taken_cnt},   32'd0);
        rst_n = 1'b1;
        step();

        // FLUSH_CYCLES=0 instance: no flush, ready right after handshake.
        br_valid0 = 1'b1; br_taken0 = 1'b1;
        pc_next0 = 32'h0000_0200; imm0 = 32'd1;
        redir_ready0 = 1'b1;
        step();
        br_valid0 = 1'b0;
        check("t6_valid", {31'd0, redir_valid0}, 32'd1);
        check("t6_pc",    redir_pc0,             32'h0000_0204);
        check("t6_nflush_a", {31'd0, flush0},    32'd0);
        step();
        check("t6_valid_off", {31'd0, redir_valid0}, 32'd0);
        check("t6_nflush_b",  {31'd0, flush0},       32'd0);
        check("t6_ready",     {31'd0, br_ready0},    32'd1);
        step();
        check("t6_nflush_c",  {31'd0, flush0},       32'd0);
        check("t6_tcnt",      {16'd0, taken_cnt0},   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
